// File: rtl/regfile_mp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_mp_pkg
// Description : Shared CPU defines for the multi-port register file.
//               Holds the default data/address widths and the index of
//               the hard-wired zero register.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_mp_pkg;

  localparam int unsigned C_DATA_W = 32;
  localparam int unsigned C_ADDR_W = 5;
  localparam int unsigned C_NRD    = 2;

  // Index of the register that reads as zero when ZERO_R0 is enabled.
  localparam int unsigned C_REG0   = 0;

endpackage : regfile_mp_pkg
`default_nettype wire

// File: rtl/regfile_mp_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_mp_if
// Description : Bus bundle for regfile_mp: two write ports, the write
//               stall, the scoreboard set request and NRD read ports.
// Ports       : master - drives writes, sets and read addresses
//               slave  - the register file; returns rdata and rbusy
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_mp_if
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W = C_DATA_W,
  parameter int ADDR_W = C_ADDR_W,
  parameter int NRD    = C_NRD
);

  logic                  stallW;
  logic                  we0;
  logic [ADDR_W-1:0]     waddr0;
  logic [DATA_W-1:0]     wdata0;
  logic                  we1;
  logic [ADDR_W-1:0]     waddr1;
  logic [DATA_W-1:0]     wdata1;
  logic [NRD*ADDR_W-1:0] raddr;
  logic [NRD*DATA_W-1:0] rdata;
  logic [NRD-1:0]        rbusy;
  logic                  set_en;
  logic [ADDR_W-1:0]     set_addr;

  modport master (
    output stallW, we0, waddr0, wdata0, we1, waddr1, wdata1,
    output raddr, set_en, set_addr,
    input  rdata, rbusy
  );

  modport slave (
    input  stallW, we0, waddr0, wdata0, we1, waddr1, wdata1,
    input  raddr, set_en, set_addr,
    output rdata, rbusy
  );

endinterface : regfile_mp_if
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scoreboard
// Description : One pending bit per register. A set marks a destination
//               as in flight, a committing write clears it; a set and a
//               clear on the same register in one cycle leaves it set.
// Ports       : clk, rst (async, active low)
//               set_en_i/set_addr_i   - mark register pending
//               clr0_en_i/clr0_addr_i - clear from write port 0
//               clr1_en_i/clr1_addr_i - clear from write port 1
//               raddr_i               - packed lookup addresses
//               rbusy_o               - pending bit per lookup port
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
  import regfile_mp_pkg::*;
#(
  parameter int ADDR_W = C_ADDR_W,
  parameter int NRD    = C_NRD
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  set_en_i,
  input  wire logic [ADDR_W-1:0]     set_addr_i,
  input  wire logic                  clr0_en_i,
  input  wire logic [ADDR_W-1:0]     clr0_addr_i,
  input  wire logic                  clr1_en_i,
  input  wire logic [ADDR_W-1:0]     clr1_addr_i,
  input  wire logic [NRD*ADDR_W-1:0] raddr_i,
  output logic      [NRD-1:0]        rbusy_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  // Clears are applied before the set so that a simultaneous set wins.
  always_comb begin
    busy_d = busy_q;
    if (clr0_en_i) busy_d[clr0_addr_i] = 1'b0;
    if (clr1_en_i) busy_d[clr1_addr_i] = 1'b0;
    if (set_en_i)  busy_d[set_addr_i]  = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Lookup is from registered state only; no forwarding of this cycle's
  // set or clear.
  generate
    for (genvar k = 0; k < NRD; k++) begin : g_lookup
      assign rbusy_o[k] = busy_q[raddr_i[k*ADDR_W +: ADDR_W]];
    end
  endgenerate

endmodule : regfile_scoreboard
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : regfile_mp
// Description : Multi-port register file with two write ports (port 1
//               has priority), NRD combinational read ports, optional
//               same-cycle write forwarding, optional hard-wired zero
//               register and a per-register pending scoreboard.
// Ports       : clk - rising-edge clock
//               rst - asynchronous active-low reset
//               bus - regfile_mp_if.slave (writes, stall, set, reads)
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W  = C_DATA_W,
  parameter int ADDR_W  = C_ADDR_W,
  parameter int NRD     = C_NRD,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 1
) (
  input  wire logic  clk,
  input  wire logic  rst,
  regfile_mp_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] C_R0_ADDR = ADDR_W'(C_REG0);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              w_commit0;
  logic              w_commit1;
  logic [NRD-1:0]    w_sb_busy;

  // A write commits only when not stalled. Writes to the zero register are
  // dropped here so neither the array, the forwarding path nor the
  // scoreboard clear ever see them.
  assign w_commit0 = bus.we0 && !bus.stallW &&
                     !((ZERO_R0 != 0) && (bus.waddr0 == C_R0_ADDR));
  assign w_commit1 = bus.we1 && !bus.stallW &&
                     !((ZERO_R0 != 0) && (bus.waddr1 == C_R0_ADDR));

  // Port 1 is written last so it wins an address collision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (w_commit0) mem_q[bus.waddr0] <= bus.wdata0;
      if (w_commit1) mem_q[bus.waddr1] <= bus.wdata1;
    end
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .NRD    (NRD)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .set_en_i    (bus.set_en),
    .set_addr_i  (bus.set_addr),
    .clr0_en_i   (w_commit0),
    .clr0_addr_i (bus.waddr0),
    .clr1_en_i   (w_commit1),
    .clr1_addr_i (bus.waddr1),
    .raddr_i     (bus.raddr),
    .rbusy_o     (w_sb_busy)
  );

  generate
    for (genvar k = 0; k < NRD; k++) begin : g_read
      logic [ADDR_W-1:0] w_ra;
      logic [DATA_W-1:0] w_rd;
      logic              w_is_r0;

      assign w_ra    = bus.raddr[k*ADDR_W +: ADDR_W];
      assign w_is_r0 = (ZERO_R0 != 0) && (w_ra == C_R0_ADDR);

      // Later assignments take precedence: port 1 forwarding beats port 0,
      // the zero register beats forwarding, and reset beats everything so
      // that nothing presented during reset leaks onto rdata.
      always_comb begin
        w_rd = mem_q[w_ra];
        if ((BYPASS != 0) && w_commit0 && (bus.waddr0 == w_ra)) w_rd = bus.wdata0;
        if ((BYPASS != 0) && w_commit1 && (bus.waddr1 == w_ra)) w_rd = bus.wdata1;
        if (w_is_r0) w_rd = '0;
        if (!rst)    w_rd = '0;
      end

      assign bus.rdata[k*DATA_W +: DATA_W] = w_rd;
      assign bus.rbusy[k] = w_sb_busy[k] && !w_is_r0 && rst;
    end
  endgenerate

endmodule : regfile_mp
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_mp
// Description : Self-checking bench for regfile_mp. Two instances share the
//               same stimulus: A uses BYPASS=1/ZERO_R0=1, B uses
//               BYPASS=0/ZERO_R0=0. A reference model of registers and
//               pending bits predicts every read port each cycle.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

  logic clk;
  logic rst;

  regfile_mp_if ifa ();
  regfile_mp_if ifb ();

  regfile_mp u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  regfile_mp #(
    .BYPASS  (0),
    .ZERO_R0 (0)
  ) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;

  // Current stimulus
  logic        s_st;
  logic        s_we0, s_we1, s_se;
  logic [4:0]  s_wa0, s_wa1, s_sa;
  logic [31:0] s_wd0, s_wd1;
  logic [4:0]  s_ra [2];

  // Reference model, index 0 = instance A, 1 = instance B
  logic [31:0] m_mem  [2][32];
  logic        m_busy [2][32];
  bit          c_byp  [2] = '{1'b1, 1'b0};
  bit          c_zero [2] = '{1'b1, 1'b0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_clear();
    for (int n = 0; n < 2; n++)
      for (int i = 0; i < 32; i++) begin
        m_mem[n][i]  = 32'h0;
        m_busy[n][i] = 1'b0;
      end
  endtask

  function automatic bit commits(int n, logic we, logic [4:0] wa);
    return we && !s_st && !(c_zero[n] && wa == 5'd0);
  endfunction

  function automatic logic [31:0] exp_rd(int n, logic [4:0] ra);
    if (!rst) return 32'h0;
    if (c_zero[n] && ra == 5'd0) return 32'h0;
    if (c_byp[n]) begin
      if (commits(n, s_we1, s_wa1) && s_wa1 == ra) return s_wd1;
      if (commits(n, s_we0, s_wa0) && s_wa0 == ra) return s_wd0;
    end
    return m_mem[n][ra];
  endfunction

  function automatic logic [31:0] exp_busy(int n, logic [4:0] ra);
    if (!rst) return 32'h0;
    if (c_zero[n] && ra == 5'd0) return 32'h0;
    return {31'h0, m_busy[n][ra]};
  endfunction

  task automatic model_edge();
    for (int n = 0; n < 2; n++) begin
      if (!rst) begin
        for (int i = 0; i < 32; i++) begin
          m_mem[n][i]  = 32'h0;
          m_busy[n][i] = 1'b0;
        end
      end else begin
        bit c0, c1;
        c0 = commits(n, s_we0, s_wa0);
        c1 = commits(n, s_we1, s_wa1);
        if (c0) m_mem[n][s_wa0] = s_wd0;
        if (c1) m_mem[n][s_wa1] = s_wd1;
        if (c0) m_busy[n][s_wa0] = 1'b0;
        if (c1) m_busy[n][s_wa1] = 1'b0;
        if (s_se) m_busy[n][s_sa] = 1'b1;
      end
    end
  endtask

  task automatic apply();
    ifa.stallW = s_st;  ifb.stallW = s_st;
    ifa.we0 = s_we0;    ifb.we0 = s_we0;
    ifa.waddr0 = s_wa0; ifb.waddr0 = s_wa0;
    ifa.wdata0 = s_wd0; ifb.wdata0 = s_wd0;
    ifa.we1 = s_we1;    ifb.we1 = s_we1;
    ifa.waddr1 = s_wa1; ifb.waddr1 = s_wa1;
    ifa.wdata1 = s_wd1; ifb.wdata1 = s_wd1;
    ifa.set_en = s_se;  ifb.set_en = s_se;
    ifa.set_addr = s_sa; ifb.set_addr = s_sa;
    ifa.raddr = {s_ra[1], s_ra[0]};
    ifb.raddr = {s_ra[1], s_ra[0]};
  endtask

  task automatic drive(input logic st,
                       input logic e0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic e1, input logic [4:0] a1, input logic [31:0] d1,
                       input logic se, input logic [4:0] sa,
                       input logic [4:0] r0, input logic [4:0] r1);
    s_st = st;
    s_we0 = e0; s_wa0 = a0; s_wd0 = d0;
    s_we1 = e1; s_wa1 = a1; s_wd1 = d1;
    s_se = se;  s_sa = sa;
    s_ra[0] = r0; s_ra[1] = r1;
    apply();
  endtask

  task automatic idle(input logic [4:0] r0, input logic [4:0] r1);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, r0, r1);
  endtask

  task automatic check_outputs();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("A.rdata%0d[r%0d]", k, s_ra[k]), ifa.rdata[k*32 +: 32], exp_rd(0, s_ra[k]));
      chk($sformatf("A.rbusy%0d[r%0d]", k, s_ra[k]), {31'h0, ifa.rbusy[k]}, exp_busy(0, s_ra[k]));
      chk($sformatf("B.rdata%0d[r%0d]", k, s_ra[k]), ifb.rdata[k*32 +: 32], exp_rd(1, s_ra[k]));
      chk($sformatf("B.rbusy%0d[r%0d]", k, s_ra[k]), {31'h0, ifb.rbusy[k]}, exp_busy(1, s_ra[k]));
    end
  endtask

  // Inputs are driven just after a rising edge; outputs are compared on the
  // falling edge, then the model advances on the next rising edge.
  task automatic cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    rst = 1'b0;
    model_clear();

    // Reset holds everything at zero even with a write and set presented.
    drive(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd5, 5'd5);
    #1;
    chk("reset_rdata_during", ifa.rdata[31:0], 32'h0);
    chk("reset_rbusy_during", {30'h0, ifa.rbusy}, 32'h0);
    cycle();
    cycle();
    rst = 1'b1;
    idle(5'd5, 5'd5);
    #1;
    chk("reset_r5_a0", ifa.rdata[31:0], 32'h0);
    chk("reset_r5_a1", ifa.rdata[63:32], 32'h0);
    chk("reset_rbusy", {30'h0, ifa.rbusy}, 32'h0);
    cycle();

    // Dual-write collision on reg 7: port 1 wins.
    drive(1'b0, 1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22, 1'b0, 5'd0, 5'd7, 5'd7);
    cycle();
    idle(5'd7, 5'd7);
    #1;
    chk("collision_A", ifa.rdata[31:0], 32'h22);
    chk("collision_B", ifb.rdata[63:32], 32'h22);
    cycle();

    // Same-cycle forwarding on A, stored value on B.
    drive(1'b0, 1'b1, 5'd3, 32'hCAFE, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd7);
    #1;
    chk("bypass_A", ifa.rdata[31:0], 32'hCAFE);
    chk("nobypass_B", ifb.rdata[31:0], 32'h0);
    cycle();
    idle(5'd3, 5'd3);
    cycle();

    // Stall blocks the write and the scoreboard clear.
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd9);
    cycle();
    drive(1'b1, 1'b1, 5'd9, 32'h55, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd9);
    cycle();
    idle(5'd9, 5'd9);
    #1;
    chk("stall_r9_data", ifa.rdata[31:0], 32'h0);
    chk("stall_r9_busy", {31'h0, ifa.rbusy[0]}, 32'h1);
    cycle();

    // Set wins over a same-cycle clear; a lone write clears.
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd4, 5'd4);
    cycle();
    drive(1'b0, 1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd4, 5'd4);
    cycle();
    idle(5'd4, 5'd4);
    #1;
    chk("sb_set_wins", {31'h0, ifa.rbusy[0]}, 32'h1);
    cycle();
    drive(1'b0, 1'b1, 5'd4, 32'h45, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd4);
    cycle();
    idle(5'd4, 5'd4);
    #1;
    chk("sb_cleared", {31'h0, ifa.rbusy[0]}, 32'h0);
    cycle();

    // Register 0: hard zero on A, ordinary register on B.
    drive(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd0);
    cycle();
    idle(5'd0, 5'd0);
    #1;
    chk("r0_A_data", ifa.rdata[31:0], 32'h0);
    chk("r0_A_busy", {31'h0, ifa.rbusy[0]}, 32'h0);
    chk("r0_B_data", ifb.rdata[31:0], 32'hFFFFFFFF);
    cycle();

    // Reset asserted mid-cycle overrides a pending write and set.
    drive(1'b0, 1'b1, 5'd10, 32'h1234, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd10, 5'd10);
    cycle();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 32'h999, 1'b1, 5'd10, 5'd10, 5'd10);
    #2;
    rst = 1'b0;
    #1;
    model_clear();
    check_outputs();
    cycle();
    rst = 1'b1;
    idle(5'd10, 5'd10);
    #1;
    chk("midreset_r10", ifa.rdata[31:0], 32'h0);
    chk("midreset_busy", {31'h0, ifa.rbusy[0]}, 32'h0);

    // First edge after release accepts writes and sets.
    drive(1'b0, 1'b1, 5'd11, 32'hA5A5, 1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 5'd11, 5'd12);
    cycle();
    idle(5'd11, 5'd12);
    cycle();

    // Randomized traffic over a narrow address window to force collisions.
    for (int it = 0; it < 600; it++) begin
      logic [4:0] a0, a1, sa, r0, r1;
      a0 = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      a1 = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      sa = 5'($urandom_range(0, 7));
      r0 = 5'($urandom_range(0, 7));
      r1 = $urandom_range(0, 3) == 0 ? a1 : 5'($urandom_range(0, 7));
      drive($urandom_range(0, 7) == 0,
            1'($urandom_range(0, 1)), a0, $urandom,
            1'($urandom_range(0, 1)), a1, $urandom,
            1'($urandom_range(0, 2) == 0), sa, r0, r1);
      if ($urandom_range(0, 99) == 0) rst = 1'b0;
      cycle();
      rst = 1'b1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_regfile_mp
`default_nettype wire
